// File: rtl/multiplier_pipelined_multimode_lanes.sv
// rtl/multiplier_pipelined_multimode_lanes.sv - pipelined multi-lane 27x18 / sum-of-9x9 / sum-of-4x4 multiplier (optional ACCUMULATE_EN)
module multiplier_pipelined_multimode_lanes #(
  parameter int LANES       = 2,
  parameter int A_W         = 27,
  parameter int PIPE_STAGES = 3,
  parameter int RES_W       = 48
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*A_W-1:0]   a,
  input  logic [LANES*A_W-1:0]   b,
  input  logic                   a_sign,
  input  logic                   b_sign,
  input  logic [1:0]             mode,
`ifdef ACCUMULATE_EN
  input  logic                   acc_en,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*RES_W-1:0] result
);

  localparam int LP = PIPE_STAGES - 1;
  localparam int HW = RES_W / 2;

  // One lane's product in the given mode; all arithmetic is done modulo the field width
  function automatic logic [47:0] lane_mul(input logic [26:0] x, input logic [26:0] y,
                                           input logic sx, input logic sy, input logic [1:0] m);
    logic [47:0] xe, ye, p00;
    logic [19:0] x9, y9, s9;
    logic [9:0]  xl, yl, xh, yh, s4l, s4h;
    logic        ext;
    xe  = {{21{sx & x[26]}}, x};
    ye  = {{30{sy & y[17]}}, y[17:0]};
    p00 = xe * ye;
    s9  = '0;
    s4l = '0;
    s4h = '0;
    for (int k = 0; k < 3; k++) begin
      x9  = {{11{sx & x[9*k+8]}}, x[9*k +: 9]};
      y9  = {{11{sy & y[9*k+8]}}, y[9*k +: 9]};
      s9  = s9 + x9 * y9;
      xl  = {{6{sx & x[9*k+3]}}, x[9*k +: 4]};
      yl  = {{6{sy & y[9*k+3]}}, y[9*k +: 4]};
      xh  = {{6{sx & x[9*k+8]}}, x[9*k+5 +: 4]};
      yh  = {{6{sy & y[9*k+8]}}, y[9*k+5 +: 4]};
      s4l = s4l + xl * yl;
      s4h = s4h + xh * yh;
    end
    ext = sx | sy;
    case (m)
      2'b00:   lane_mul = p00;
      2'b01:   lane_mul = {{28{ext & s9[19]}}, s9};
      2'b10:   lane_mul = {{14{ext & s4h[9]}}, s4h, {14{ext & s4l[9]}}, s4l};
      default: lane_mul = '0;
    endcase
  endfunction

  logic [PIPE_STAGES-1:0]   vld_q;
  logic [LANES*A_W-1:0]     a_q, b_q;
  logic                     sa_q, sb_q;
  logic [1:0]               mode_q;
  logic [LANES*RES_W-1:0]   res_q  [1:LP];
  logic [LANES*RES_W-1:0]   stg_in [1:LP];
  logic [LANES*RES_W-1:0]   prod_comb;
  logic [LANES*RES_W-1:0]   last_val;
  logic                     advance;

  // whole pipeline moves together unless the output is held
  assign advance   = out_ready | ~vld_q[LP];
  assign in_ready  = advance;
  assign out_valid = vld_q[LP];
  assign result    = res_q[LP];

  assign stg_in[1] = prod_comb;
  for (genvar s = 2; s <= LP; s++) begin : g_chain
    assign stg_in[s] = res_q[s-1];
  end

  // per-lane product from the captured operands
  always_comb begin
    prod_comb = '0;
    for (int i = 0; i < LANES; i++)
      prod_comb[i*RES_W +: RES_W] = lane_mul(a_q[i*A_W +: A_W], b_q[i*A_W +: A_W], sa_q, sb_q, mode_q);
  end

  // stage valid bits shift on every advancing cycle, bubbles included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_q <= '0;
    else if (advance) vld_q <= {vld_q[LP-1:0], in_valid};
  end

  // operand capture stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      mode_q <= 2'b00;
    end else if (advance && in_valid) begin
      a_q    <= a;
      b_q    <= b;
      sa_q   <= a_sign;
      sb_q   <= b_sign;
      mode_q <= mode;
    end
  end

  // result stages load only when a valid transaction moves in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 1; s <= LP; s++) res_q[s] <= '0;
    end else if (advance) begin
      for (int s = 1; s < LP; s++)
        if (vld_q[s-1]) res_q[s] <= stg_in[s];
      if (vld_q[LP-1]) res_q[LP] <= last_val;
    end
  end

`ifdef ACCUMULATE_EN
  logic [1:0]       md_s [0:LP-1];
  logic             ae_s [0:LP-1];
  logic [RES_W-1:0] acc_q [LANES];

  // mode and acc_en ride alongside the data so the last stage knows how to accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LP; s++) begin
        md_s[s] <= 2'b00;
        ae_s[s] <= 1'b0;
      end
    end else if (advance) begin
      if (in_valid) begin
        md_s[0] <= mode;
        ae_s[0] <= acc_en;
      end
      for (int s = 1; s < LP; s++)
        if (vld_q[s-1]) begin
          md_s[s] <= md_s[s-1];
          ae_s[s] <= ae_s[s-1];
        end
    end
  end

  // add to the running accumulator; mode 10 keeps two independent half-width fields
  always_comb begin
    last_val = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!ae_s[LP-1])
        last_val[i*RES_W +: RES_W] = stg_in[LP][i*RES_W +: RES_W];
      else if (md_s[LP-1] == 2'b10) begin
        last_val[i*RES_W+HW +: HW] = acc_q[i][HW +: HW] + stg_in[LP][i*RES_W+HW +: HW];
        last_val[i*RES_W +: HW]    = acc_q[i][0 +: HW]  + stg_in[LP][i*RES_W +: HW];
      end else
        last_val[i*RES_W +: RES_W] = acc_q[i] + stg_in[LP][i*RES_W +: RES_W];
    end
  end

  // accumulators follow the value delivered into the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else if (advance && vld_q[LP-1]) begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= last_val[i*RES_W +: RES_W];
    end
  end
`else
  assign last_val = stg_in[LP];
`endif

endmodule

// File: tb/tb_multiplier_pipelined_multimode_lanes.sv
// tb/tb_multiplier_pipelined_multimode_lanes.sv - scoreboard bench for the multimode multiplier lanes
module tb_multiplier_pipelined_multimode_lanes;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [53:0] a, b;
  logic        a_sign, b_sign;
  logic [1:0]  mode;
  logic        acc_en;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] result;

  always #5 clk = ~clk;

  multiplier_pipelined_multimode_lanes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_sign    (a_sign),
    .b_sign    (b_sign),
    .mode      (mode),
`ifdef ACCUMULATE_EN
    .acc_en    (acc_en),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  typedef struct {
    logic [26:0] a0, b0, a1, b1;
    logic        sa, sb;
    logic [1:0]  m;
    logic        ae;
    logic [47:0] e0, e1;
  } vec_t;

  vec_t        vt [11];
  logic [95:0] exp_q [$];
  int          lat_q [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_out = 0;
  bit          lat_chk = 1'b1;
  logic [95:0] mon_exp;
  int          mon_t;

  always @(posedge clk) cyc++;

  function automatic vec_t mk(input logic [26:0] a0, input logic [26:0] b0, input logic [26:0] a1,
                              input logic [26:0] b1, input logic sa, input logic sb, input logic [1:0] m,
                              input logic [47:0] e0, input logic [47:0] e1);
    vec_t v;
    v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
    v.sa = sa; v.sb = sb; v.m = m; v.ae = 1'b0;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // monitor: every delivered result is checked against the head of the scoreboard
  always @(negedge clk) begin
    #2;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", result);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_t   = lat_q.pop_front();
        chk("result", result, mon_exp);
        if (lat_chk) chk("latency", 96'(cyc - mon_t), 96'd3);
      end
    end
  end

  task automatic send(input vec_t v);
    int w;
    @(negedge clk);
    a        = {v.a1, v.a0};
    b        = {v.b1, v.b0};
    a_sign   = v.sa;
    b_sign   = v.sb;
    mode     = v.m;
    acc_en   = v.ae;
    in_valid = 1'b1;
    #2;
    w = 0;
    while (!in_ready && w <= 50) begin
      @(negedge clk);
      #2;
      w++;
    end
    if (in_ready) begin
      exp_q.push_back({v.e1, v.e0});
      lat_q.push_back(cyc);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int order [10];
    vec_t av;
    vt[0]  = mk(27'h7FFFFFF, 27'h003FFFF, 27'h0000003, 27'h0000005, 0, 0, 2'b00, 48'h1FFFF7FC0001, 48'h00000000000F);
    vt[1]  = mk(27'h7FFFFFF, 27'h7FFFFFE, 27'h7FFFFFD, 27'h0000004, 1, 1, 2'b00, 48'h000000000002, 48'hFFFFFFFFFFF4);
    vt[2]  = mk(27'h7FFFFFF, 27'h0000002, 27'h7FFFFFF, 27'h003FFFF, 1, 0, 2'b00, 48'hFFFFFFFFFFFE, 48'hFFFFFFFC0001);
    vt[3]  = mk(27'h4020100, 27'h4020100, 27'h0040403, 27'h7FFFFFF, 1, 1, 2'b01, 48'h000000030000, 48'hFFFFFFFFFFFA);
    vt[4]  = mk(27'h4020100, 27'h3FDFEFF, 27'h0040403, 27'h3FDFEFF, 1, 0, 2'b01, 48'hFFFFFFFD0300, 48'h0000000005FA);
    vt[5]  = mk(27'h7FFFFFF, 27'h7FFFFFF, 27'h0000000, 27'h7FFFFFF, 0, 0, 2'b01, 48'h0000000BF403, 48'h000000000000);
    vt[6]  = mk(27'h7FFFFFF, 27'h7FFFFFF, 27'h7BFDFEF, 27'h7FFFFFF, 0, 0, 2'b10, 48'h0002A30002A3, 48'h0002A30002A3);
    vt[7]  = mk(27'h4221108, 27'h4221108, 27'h4221108, 27'h39DCEE7, 1, 1, 2'b10, 48'h0000C00000C0, 48'hFFFF58FFFF58);
    vt[8]  = mk(27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFF, 1, 1, 2'b11, 48'h000000000000, 48'h000000000000);
    vt[9]  = mk(27'h00003E8, 27'h00003E8, 27'h4000000, 27'h0020000, 0, 0, 2'b00, 48'h0000000F4240, 48'h080000000000);
    vt[10] = mk(27'h4000000, 27'h0020000, 27'h4000000, 27'h0000001, 1, 1, 2'b00, 48'h080000000000, 48'hFFFFFC000000);
    order = '{0, 3, 6, 1, 4, 7, 8, 9, 5, 6};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; a_sign = 1'b0; b_sign = 1'b0; mode = 2'b00; acc_en = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_out_valid", 96'(out_valid), 96'd0);
    chk("reset_in_ready", 96'(in_ready), 96'd1);
    chk("reset_result", result, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single transaction: latency, value, one-cycle out_valid
    send(vt[0]);
    idle();
    drain();
    #2;
    chk("single_pulse_out_valid", 96'(out_valid), 96'd0);

    // every directed vector back to back
    for (int i = 1; i < 11; i++) send(vt[i]);
    idle();
    drain();

    // alternating modes with a 4-cycle downstream stall
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(vt[order[i]]);
        idle();
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) begin
          #2;
          chk("stall_in_ready", 96'(in_ready), 96'd0);
          chk("stall_out_valid", 96'(out_valid), 96'd1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    lat_chk = 1'b1;

    // reset with transactions in flight
    for (int i = 0; i < 3; i++) send(vt[i + 3]);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flight_reset_out_valid", 96'(out_valid), 96'd0);
    chk("flight_reset_result", result, 96'd0);
    exp_q.delete();
    lat_q.delete();
    n_out = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_stale_results", 96'(n_out), 96'd0);
    send(vt[7]);
    idle();
    drain();

`ifdef ACCUMULATE_EN
    for (int i = 0; i < 3; i++) begin
      av = mk(27'd1, 27'd1, 27'd2, 27'd3, 0, 0, 2'b00, 48'(i + 1), 48'(6 * (i + 1)));
      av.ae = (i != 0);
      send(av);
    end
    idle();
    drain();
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
